fruit_template_sad_matcher: RTL
===============================

// Module: fruit_template_sad_matcher
// PURPOSE
//  Sweeps one fruit template ROM (2048 x 8, 1-cycle registered read) in lockstep with a captured
//  feature buffer (same geometry, same latency). Computes the sum of absolute differences (SAD) and
//  flags a match against a threshold. Sits directly upstream of the template ROM: drives its addr
//  and consumes its rd_data. The score feeds the fruit classifier's arg-min stage.
// PARAMETERS
//  ADDR_WIDTH   11        template/feature address width
//  DATA_WIDTH   8         template/feature byte width (unsigned)
//  NUM_ENTRIES  2048      entries swept per run, 1..2**ADDR_WIDTH (reduced in simulation)
//  ACC_WIDTH    19        SAD accumulator width = ADDR_WIDTH+DATA_WIDTH; cannot overflow
// PORTS
//  clk        in   1           single clock for all logic
//  rst        in   1           synchronous, active-high reset
//  start      in   1           1-cycle request; accepted only in IDLE
//  threshold  in   ACC_WIDTH   match limit, sampled on accepted start
//  busy       out  1           high from the cycle after accept until done, inclusive
//  rom_addr   out  ADDR_WIDTH  template ROM address
//  rom_data   in   DATA_WIDTH  template ROM read data, valid 1 cycle after rom_addr
//  feat_addr  out  ADDR_WIDTH  feature buffer address, always equal to rom_addr
//  feat_data  in   DATA_WIDTH  feature read data, valid 1 cycle after feat_addr
//  done       out  1           1-cycle pulse: score/match/aborted valid
//  score      out  ACC_WIDTH   SAD result, held until next accepted start
//  match      out  1           score <= threshold_latched, held with score
//  aborted    out  1           run terminated early (EARLY_ABORT_EN only, else 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, match, aborted = 0; score, rom_addr, feat_addr, acc = 0.
//  FSM: IDLE -start-> RUN -(addr==NUM_ENTRIES-1 issued)-> DRAIN -(pipe empty)-> DONE -> IDLE.
//  start is ignored while not IDLE (no queueing). DONE lasts exactly one cycle; done=1 in it.
//  Pipeline, start accepted in cycle 0: cycles 1..N drive addr i=0..N-1. Data for i is sampled
//   in cycle i+2. |rom-feat| is registered in cycle i+3; acc includes i in cycle i+4.
//   done and score are in cycle N+3 (N=2048 -> cycle 2051).
//  |diff|: 9-bit subtract, 8-bit unsigned magnitude, zero-extended into acc. No saturation needed.
//  acc clears on accepted start. score/match update only when done pulses.
//  Address holds at N-1 during DRAIN/DONE and returns to 0 in IDLE.
//  rst mid-run: immediate return to IDLE, no done pulse, outputs to reset values.
//  start together with rst: rst wins.
//  threshold changes after accept: no effect on the current run.
// CONFIGURATION
//  `define FRUIT_SAD_EARLY_ABORT_EN
//   With it: in RUN, if acc > threshold_latched, stop issuing addresses and go to DRAIN.
//    In-flight samples still accumulate. Then DONE with match=0, aborted=1, score = acc at drain end.
//   Without it: always a full sweep; aborted tied to 0. Timing is exactly N+3 cycles.
// STRUCTURE
//  Package fruit_match_pkg holds:
//   - state enum {IDLE,RUN,DRAIN,DONE};
//   - ADDR_WIDTH/DATA_WIDTH/ACC_WIDTH defaults;
//   - pipeline depth localparam PIPE_LAT=3.
//  Sub-module fruit_sad_pipe: data-sample, absdiff and accumulate stages. It has a valid shift
//   chain and a clear input. The top holds the FSM and address counter.
// TESTING
//  1 Template all 0x10, feature all 0x10, thr=0, N=2048 -> done at cycle 2051, score=0, match=1.
//  2 Template 0x10, feature 0x20, thr=32767 -> score=32768, match=0. Same with thr=32768 -> match=1.
//  3 Template 0x00, feature 0xFF, N=2048 -> score=522240 (no overflow), busy high cycles 1..2051.
//  4 Second start pulsed in cycle 100 of a run -> ignored; exactly one done; score unchanged by it.
//  5 rst asserted in cycle 500 of a run -> next cycle IDLE, busy=0, no done. A new start then
//    completes normally.
//  6 EARLY_ABORT_EN: template 0x00, feature 0xFF, thr=1000 -> aborted=1, match=0, done well before
//    cycle 2051, score in [1020,1785].
//    Without the macro, same stimulus -> full run, aborted=0.

Source files
------------

// File: rtl/fruit_match_pkg.sv
// Shared widths, pipeline depth and FSM state encodings for the fruit template SAD matcher.
package fruit_match_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = ADDR_WIDTH_DEF + DATA_WIDTH_DEF;

  // Address issue -> data sample -> absdiff register -> accumulator
  localparam int PIPE_LAT = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/fruit_sad_pipe.sv
// Data-sample, absolute-difference and accumulate stages of the SAD sweep; the valid
// shift chain tracks which cycles carry ROM/feature data issued by the address counter.
module fruit_sad_pipe
  import fruit_match_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  issue_vld_i,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic [DATA_WIDTH-1:0] feat_data_i,
  output logic                  drain_done_o,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic [ACC_WIDTH-1:0]  acc_next_o
);

  // vld_q[0]: read data present this cycle; vld_q[last]: diff_q holds a sample to add
  logic [PIPE_LAT-2:0]   vld_q, vld_d;
  logic [DATA_WIDTH:0]   diff_full;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;

  always_comb begin
    vld_d     = {vld_q[PIPE_LAT-3:0], issue_vld_i};
    diff_full = {1'b0, rom_data_i} - {1'b0, feat_data_i};
    mag       = diff_full[DATA_WIDTH] ? DATA_WIDTH'(-diff_full) : diff_full[DATA_WIDTH-1:0];
    diff_d    = vld_q[0] ? mag : diff_q;
    acc_d     = acc_q;
    if (vld_q[PIPE_LAT-2]) begin
      acc_d = acc_q + ACC_WIDTH'(diff_q);
    end
    if (clear_i) begin
      vld_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      diff_q <= '0;
      acc_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      diff_q <= diff_d;
      acc_q  <= acc_d;
    end
  end

  // Only the final accumulate is still pending once the earlier stages are empty
  assign drain_done_o = ~|vld_q[PIPE_LAT-3:0];
  assign acc_o        = acc_q;
  assign acc_next_o   = acc_d;

endmodule

// File: rtl/fruit_template_sad_matcher.sv
// Sweeps template ROM and feature buffer in lockstep, accumulates SAD, flags score <= threshold.
// Full sweep: done N+3 cycles after accepted start. Optional early abort: FRUIT_SAD_EARLY_ABORT_EN.
module fruit_template_sad_matcher
  import fruit_match_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_ENTRIES = 2048,
  parameter int ACC_WIDTH   = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ACC_WIDTH-1:0]  threshold,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] feat_addr,
  input  logic [DATA_WIDTH-1:0] feat_data,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  score,
  output logic                  match,
  output logic                  aborted
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ACC_WIDTH-1:0]  thr_q, thr_d;
  logic [ACC_WIDTH-1:0]  score_q, score_d;
  logic                  match_q, match_d;

  logic                  accept;
  logic                  issue_vld;
  logic                  abort_hit;
  logic                  abort_flag;
  logic                  drain_done;
  logic                  drain_exit;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  acc_next;

  assign accept     = (state_q == IDLE) && start;
  assign issue_vld  = (state_q == RUN) && !abort_hit;
  assign drain_exit = (state_q == DRAIN) && drain_done;

`ifdef FRUIT_SAD_EARLY_ABORT_EN
  logic abort_seen_q;
  logic aborted_q;

  // Once the partial sum exceeds the limit the run can no longer match
  assign abort_hit  = (state_q == RUN) && (acc > thr_q);
  assign abort_flag = abort_seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      abort_seen_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      if (accept) begin
        abort_seen_q <= 1'b0;
      end else if (abort_hit) begin
        abort_seen_q <= 1'b1;
      end
      if (drain_exit) begin
        aborted_q <= abort_seen_q;
      end
    end
  end

  assign aborted = aborted_q;
`else
  assign abort_hit  = 1'b0;
  assign abort_flag = 1'b0;
  assign aborted    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    thr_d   = thr_q;
    score_d = score_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d = RUN;
          thr_d   = threshold;
        end
      end
      RUN: begin
        if (abort_hit || (addr_q == LAST_ADDR)) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = DONE;
          score_d = acc_next;
          match_d = (acc_next <= thr_q) && !abort_flag;
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      thr_q   <= '0;
      score_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      thr_q   <= thr_d;
      score_q <= score_d;
      match_q <= match_d;
    end
  end

  fruit_sad_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (accept),
    .issue_vld_i  (issue_vld),
    .rom_data_i   (rom_data),
    .feat_data_i  (feat_data),
    .drain_done_o (drain_done),
    .acc_o        (acc),
    .acc_next_o   (acc_next)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rom_addr  = addr_q;
  assign feat_addr = addr_q;
  assign score     = score_q;
  assign match     = match_q;

endmodule
